// File: rtl/iterative_shifter_pkg.sv
// Shared types for iterative_shifter: op encoding, FSM states and op legality.
// Define SHIFTER_ROTATE_EN to make ROL/ROR legal operations.
package iterative_shifter_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } shift_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } shifter_state_e;

   function automatic logic op_legal(input logic [2:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_SLL, OP_SRL, OP_SRA: legal = 1'b1;
`ifdef SHIFTER_ROTATE_EN
         OP_ROL, OP_ROR:         legal = 1'b1;
`endif
         default:                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single-step shifter: moves data by k (0..STEP) positions through a
// log2(STEP+1)-stage mux tree. Rotation is only built with SHIFTER_ROTATE_EN.
module iterative_shifter_shift_step
   import iterative_shifter_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 1,
   localparam int unsigned KW  = $clog2(STEP + 1)
) (
   input  logic [XLEN-1:0] data_i,
   input  shift_op_e       op_i,
   input  logic [KW-1:0]   k_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] acc;

   // Stage j moves by 2**j when bit j of k is set.
   always_comb begin
      acc = data_i;
      for (int unsigned j = 0; j < KW; j++) begin
         if (k_i[j]) begin
            case (op_i)
               OP_SLL:  acc = acc << (1 << j);
               OP_SRL:  acc = acc >> (1 << j);
               OP_SRA:  acc = $unsigned($signed(acc) >>> (1 << j));
`ifdef SHIFTER_ROTATE_EN
               OP_ROL:  acc = (acc << (1 << j)) | (acc >> (XLEN - (1 << j)));
               OP_ROR:  acc = (acc >> (1 << j)) | (acc << (XLEN - (1 << j)));
`endif
               default: acc = acc;
            endcase
         end
      end
      data_o = acc;
   end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle RV32I shift unit: up to STEP positions per cycle, valid/ready on both sides.
// Optional ROL/ROR support is enabled by defining SHIFTER_ROTATE_EN.
module iterative_shifter
   import iterative_shifter_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] rd_o
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);
   localparam int unsigned KW      = $clog2(STEP + 1);

   shifter_state_e     state_q, state_d;
   logic [XLEN-1:0]    data_q, data_d, step_out;
   logic [SHAMT_W-1:0] rem_q, rem_d, shamt;
   shift_op_e          op_q, op_d;
   logic [KW-1:0]      k;
   logic               unused_rs2;

   assign shamt      = rs2_i[SHAMT_W-1:0];
   assign unused_rs2 = ^rs2_i[XLEN-1:SHAMT_W];

   always_comb begin
      if (rem_q > SHAMT_W'(STEP)) begin
         k = KW'(STEP);
      end else begin
         k = KW'(rem_q);
      end
   end

   iterative_shifter_shift_step #(
      .XLEN(XLEN),
      .STEP(STEP)
   ) u_shift_step (
      .data_i(data_q),
      .op_i  (op_q),
      .k_i   (k),
      .data_o(step_out)
   );

   // Flush masks both handshakes combinationally so nothing transfers in that cycle.
   always_comb begin
      ready_o = (state_q == StIdle) && !flush_i;
      valid_o = (state_q == StDone) && !flush_i;
      rd_o    = (state_q == StDone) ? data_q : '0;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      op_d    = op_q;
      if (flush_i) begin
         state_d = StIdle;
         rem_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  data_d = rs1_i;
                  op_d   = shift_op_e'(op_i);
                  rem_d  = shamt;
                  // Zero shifts and illegal ops return rs1 unchanged.
                  if ((shamt == '0) || !op_legal(op_i)) begin
                     rem_d   = '0;
                     state_d = StDone;
                  end else begin
                     state_d = StShift;
                  end
               end
            end
            StShift: begin
               data_d = step_out;
               rem_d  = rem_q - SHAMT_W'(k);
               if (rem_d == '0) begin
                  state_d = StDone;
               end
            end
            StDone: begin
               if (ready_i) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         data_q  <= '0;
         rem_q   <= '0;
         op_q    <= OP_SLL;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: three instances with STEP 1, 8 and 2,
// table vectors, hand-written corner sequences and randomized back-to-back traffic.
module tb_iterative_shifter;

   localparam int ND = 3;

   typedef struct {
      int          d;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rd;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush    [ND];
   logic        valid_in [ND];
   logic        ready_in [ND];
   logic [2:0]  op       [ND];
   logic [31:0] rs1      [ND];
   logic [31:0] rs2      [ND];
   logic        rdy_o    [ND];
   logic        vld_o    [ND];
   logic [31:0] rd       [ND];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 8 : 2);
      iterative_shifter #(
         .XLEN(32),
         .STEP(S)
      ) u_dut (
         .clk_i  (clk),
         .rst_i  (rst),
         .flush_i(flush[g]),
         .valid_i(valid_in[g]),
         .ready_o(rdy_o[g]),
         .op_i   (op[g]),
         .rs1_i  (rs1[g]),
         .rs2_i  (rs2[g]),
         .valid_o(vld_o[g]),
         .ready_i(ready_in[g]),
         .rd_o   (rd[g])
      );
   end

   function automatic int step_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 8 : 2);
   endfunction

   function automatic bit legal(input logic [2:0] o);
`ifdef SHIFTER_ROTATE_EN
      return o <= 3'd4;
`else
      return o <= 3'd2;
`endif
   endfunction

   // Reference result straight from the shift definitions.
   function automatic logic [31:0] ref_rd(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
      int          s = int'(b[4:0]);
      logic [63:0] t;
      if (!legal(o)) return a;
      case (o)
         3'd0:    return a << s;
         3'd1:    return a >> s;
         3'd2:    return 32'($signed(a) >>> s);
         3'd3: begin
            t = {a, a} << s;
            return t[63:32];
         end
         default: begin
            t = {a, a} >> s;
            return t[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input int d, input logic [2:0] o, input logic [31:0] b);
      int s = int'(b[4:0]);
      if (!legal(o) || s == 0) return 1;
      return 1 + (s + step_of(d) - 1) / step_of(d);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // One full transaction; holds ready_i low for 'hold' cycles once the result is up.
   task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic [31:0] exp_rd,
                        output logic [31:0] res, output int lat);
      int n;
      @(negedge clk);
      op[d] = o; rs1[d] = a; rs2[d] = b; valid_in[d] = 1'b1; ready_in[d] = 1'b0;
      n = 0;
      while (!rdy_o[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("ready_before_accept[%0d]", d), 32'(rdy_o[d]), 32'd1);
      @(posedge clk);
      #1 valid_in[d] = 1'b0;
      lat = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (vld_o[d]) break;
      end
      res = rd[d];
      check($sformatf("ready_in_done[%0d]", d), 32'(rdy_o[d]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(vld_o[d]), 32'd1);
         check("hold_rd", rd[d], exp_rd);
         check("hold_ready", 32'(rdy_o[d]), 32'd0);
      end
      ready_in[d] = 1'b1;
      @(negedge clk);
      ready_in[d] = 1'b0;
      #1 check($sformatf("valid_drop[%0d]", d), 32'(vld_o[d]), 32'd0);
   endtask

   task automatic drive_rand(input int d, output logic [2:0] o, output logic [31:0] a,
                             output logic [31:0] b);
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      op[d] = o; rs1[d] = a; rs2[d] = b; valid_in[d] = 1'b1;
   endtask

   // valid_i held high, ready_i high: checks ordering, values and accept spacing.
   task automatic b2b(input int d, input int n_ops);
      exp_t        q[$];
      int          acc = 0, got = 0, last_c = -1, last_lat = 0, cyc = 0;
      logic [2:0]  o;
      logic [31:0] a, b;
      ready_in[d] = 1'b1;
      @(negedge clk);
      drive_rand(d, o, a, b);
      #1;
      while (got < n_ops && cyc < 4000) begin
         if (vld_o[d]) begin
            if (q.size() == 0) begin
               check("b2b_spurious_valid", 32'd1, 32'd0);
            end else begin
               check($sformatf("b2b_rd[%0d]", d), rd[d], q[0].rd);
               void'(q.pop_front());
            end
            got++;
         end
         if (rdy_o[d] && valid_in[d]) begin
            q.push_back('{ref_rd(o, a, b), ref_lat(d, o, b)});
            if (last_c >= 0) check($sformatf("b2b_period[%0d]", d), 32'(cyc - last_c),
                                   32'(last_lat + 1));
            last_c   = cyc;
            last_lat = ref_lat(d, o, b);
            acc++;
            @(posedge clk);
            #1;
            if (acc < n_ops) drive_rand(d, o, a, b);
            else valid_in[d] = 1'b0;
         end
         @(negedge clk);
         #1;
         cyc++;
      end
      check($sformatf("b2b_count[%0d]", d), 32'(got), 32'(n_ops));
      ready_in[d] = 1'b0;
      valid_in[d] = 1'b0;
   endtask

   initial begin
      vec_t        tab[$];
      logic [31:0] res;
      int          lat;
      int          seen;

      rst = 1'b1;
      for (int i = 0; i < ND; i++) begin
         flush[i] = 1'b0; valid_in[i] = 1'b0; ready_in[i] = 1'b0;
         op[i] = 3'd0; rs1[i] = '0; rs2[i] = '0;
      end
      #12 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < ND; i++) begin
         check($sformatf("reset_ready[%0d]", i), 32'(rdy_o[i]), 32'd1);
         check($sformatf("reset_valid[%0d]", i), 32'(vld_o[i]), 32'd0);
         check($sformatf("reset_rd[%0d]", i), rd[i], 32'd0);
      end

      tab.push_back('{0, 3'd0, 32'h0000_0001, 32'd31,        32'h8000_0000, 32});
      tab.push_back('{1, 3'd2, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 2});
      tab.push_back('{1, 3'd1, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 2});
      tab.push_back('{0, 3'd0, 32'h1234_5678, 32'd32,        32'h1234_5678, 1});
      tab.push_back('{1, 3'd7, 32'hCAFE_F00D, 32'd5,         32'hCAFE_F00D, 1});
      tab.push_back('{1, 3'd0, 32'h1234_5679, 32'd31,        32'h8000_0000, 5});
      tab.push_back('{1, 3'd2, 32'h8000_0001, 32'd31,        32'hFFFF_FFFF, 5});
      tab.push_back('{2, 3'd1, 32'hFFFF_FFFF, 32'd7,         32'h01FF_FFFF, 5});
      tab.push_back('{2, 3'd2, 32'h7000_0000, 32'd3,         32'h0E00_0000, 3});
`ifdef SHIFTER_ROTATE_EN
      tab.push_back('{2, 3'd4, 32'h0000_00F1, 32'd4,         32'h1000_000F, 3});
      tab.push_back('{1, 3'd3, 32'h8000_0001, 32'd9,         32'h0000_0300, 3});
`else
      tab.push_back('{2, 3'd4, 32'h0000_00F1, 32'd4,         32'h0000_00F1, 1});
      tab.push_back('{1, 3'd3, 32'h8000_0001, 32'd9,         32'h8000_0001, 1});
`endif
      foreach (tab[i]) begin
         do_op(tab[i].d, tab[i].op, tab[i].a, tab[i].b, 0, tab[i].rd, res, lat);
         check($sformatf("tab_rd[%0d]", i), res, tab[i].rd);
         check($sformatf("tab_lat[%0d]", i), 32'(lat), 32'(tab[i].lat));
      end

      // Shamt 0 with the consumer stalled for five cycles.
      do_op(0, 3'd1, 32'hDEAD_BEEF, 32'd0, 5, 32'hDEAD_BEEF, res, lat);
      check("stall_rd", res, 32'hDEAD_BEEF);
      check("stall_lat", 32'(lat), 32'd1);

      // Flush in the third SHIFT cycle of a 20-bit SLL.
      @(negedge clk);
      op[0] = 3'd0; rs1[0] = 32'h1; rs2[0] = 32'd20; valid_in[0] = 1'b1;
      @(posedge clk);
      #1 valid_in[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("flush_shift_ready", 32'(rdy_o[0]), 32'd0);
      flush[0] = 1'b1;
      @(negedge clk);
      flush[0] = 1'b0;
      #1;
      check("flush_ready", 32'(rdy_o[0]), 32'd1);
      check("flush_valid", 32'(vld_o[0]), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (vld_o[0]) seen++;
      end
      check("flush_no_valid", 32'(seen), 32'd0);

      // Flush together with a request in IDLE: nothing is accepted.
      op[0] = 3'd1; rs1[0] = 32'h5; rs2[0] = 32'd0; valid_in[0] = 1'b1; flush[0] = 1'b1;
      @(negedge clk);
      valid_in[0] = 1'b0; flush[0] = 1'b0;
      #1;
      check("flush_idle_valid", 32'(vld_o[0]), 32'd0);
      check("flush_idle_ready", 32'(rdy_o[0]), 32'd1);
      @(negedge clk);
      check("flush_idle_valid2", 32'(vld_o[0]), 32'd0);

      // Asynchronous reset in the middle of a shift.
      op[0] = 3'd0; rs1[0] = 32'h3; rs2[0] = 32'd20; valid_in[0] = 1'b1;
      @(posedge clk);
      #1 valid_in[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_ready", 32'(rdy_o[0]), 32'd1);
      check("rst_mid_valid", 32'(vld_o[0]), 32'd0);
      check("rst_mid_rd", rd[0], 32'd0);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (vld_o[0]) seen++;
      end
      check("rst_no_stale_valid", 32'(seen), 32'd0);

      for (int d = 0; d < ND; d++) b2b(d, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
